// File: rtl/evict_write_buffer_if.sv
// Bus bundle for evict_write_buffer: push port from the cache, RAM write
// port, read-miss lookup probe, flush request and occupancy status.
// The master side is the environment (cache + RAM); the slave side is the buffer.
interface evict_write_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                    push_valid;
    logic [ADDR_WIDTH-1:0]   push_addr;
    logic [DATA_WIDTH-1:0]   push_data;
    logic                    push_ready;
    logic                    ram_busy;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wd;
    logic [ADDR_WIDTH-1:0]   lk_addr;
    logic                    lk_hit;
    logic [DATA_WIDTH-1:0]   lk_data;
    logic                    flush;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output push_valid, push_addr, push_data, ram_busy, lk_addr, flush,
        input  push_ready, ram_we, ram_waddr, ram_wd, lk_hit, lk_data, empty, count
    );

    modport slave (
        input  push_valid, push_addr, push_data, ram_busy, lk_addr, flush,
        output push_ready, ram_we, ram_waddr, ram_wd, lk_hit, lk_data, empty, count
    );
endinterface

// File: rtl/evict_write_buffer.sv
// Evict/write-through buffer: a circular FIFO of (address, data) words that
// drains into a RAM write port whenever the RAM is not busy, with a
// word-granular lookup so read misses can forward pending data.
// Optional feature macro: WB_COALESCE_EN -- a push whose word address matches
// a pending entry (other than the head being popped) overwrites that entry.
module evict_write_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    evict_write_buffer_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH
    } state_t;

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    state_t                r_state;
    state_t                w_state_next;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_alloc;
    logic [CW-1:0]         w_count_next;
    logic                  w_lk_hit;
    logic [DATA_WIDTH-1:0] w_lk_data;
    logic [PW-1:0]         w_idx;
`ifdef WB_COALESCE_EN
    logic                  w_coal_match;
    logic [PW-1:0]         w_coal_idx;
`endif

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_count != '0) && !bus.ram_busy;

    // Scan pending entries oldest to newest so the newest match wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first; without it a
        // path that skips an assignment infers a latch.
        w_lk_hit  = 1'b0;
        w_lk_data = '0;
        w_idx     = '0;
`ifdef WB_COALESCE_EN
        w_coal_match = 1'b0;
        w_coal_idx   = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (CW'(k) < r_count) begin
                if (r_addr[w_idx][ADDR_WIDTH-1:2] == bus.lk_addr[ADDR_WIDTH-1:2]) begin
                    w_lk_hit  = 1'b1;
                    w_lk_data = r_data[w_idx];
                end
`ifdef WB_COALESCE_EN
                // The head leaving this cycle cannot absorb a merge.
                if ((r_addr[w_idx][ADDR_WIDTH-1:2] == bus.push_addr[ADDR_WIDTH-1:2]) &&
                    !((k == 0) && w_pop)) begin
                    w_coal_match = 1'b1;
                    w_coal_idx   = w_idx;
                end
`endif
            end
        end
    end

`ifdef WB_COALESCE_EN
    assign bus.push_ready = !bus.flush && (!w_full || w_coal_match);
    assign w_push         = bus.push_valid && bus.push_ready;
    assign w_alloc        = w_push && !w_coal_match;
`else
    assign bus.push_ready = !bus.flush && !w_full;
    assign w_push         = bus.push_valid && bus.push_ready;
    assign w_alloc        = w_push;
`endif

    assign w_count_next  = r_count + CW'(w_alloc) - CW'(w_pop);

    assign bus.ram_we    = w_pop;
    assign bus.ram_waddr = w_pop ? r_addr[r_head] : '0;
    assign bus.ram_wd    = w_pop ? r_data[r_head] : '0;
    assign bus.lk_hit    = w_lk_hit;
    assign bus.lk_data   = w_lk_data;
    assign bus.empty     = (r_count == '0);
    assign bus.count     = r_count;

    // Pointer and occupancy update; reset discards every pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            if (w_alloc) r_tail <= r_tail + PW'(1);
            if (w_pop)   r_head <= r_head + PW'(1);
            r_count <= w_count_next;
        end
    end

    // Entry storage write: allocate at tail, or merge into a matching entry.
    // NOTE: the storage array is deliberately not reset; validity comes from
    // head/count, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= bus.push_addr;
            r_data[r_tail] <= bus.push_data;
        end
`ifdef WB_COALESCE_EN
        else if (w_push) begin
            r_data[w_coal_idx] <= bus.push_data;
        end
`endif
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Drain FSM next-state: flush dominates, otherwise track occupancy.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.flush)   w_state_next = S_FLUSH;
                else if (w_alloc) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.flush)                w_state_next = S_FLUSH;
                else if (w_count_next == '0)  w_state_next = S_IDLE;
            end
            S_FLUSH: begin
                if (!bus.flush)
                    w_state_next = (w_count_next == '0) ? S_IDLE : S_DRAIN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_evict_write_buffer.sv
// Directed bench for evict_write_buffer. Expected RAM writes are queued when
// pushes are driven and compared by a write monitor as the DUT drains them.
module tb_evict_write_buffer;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    evict_write_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    evict_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t sb[$];
    int  n_cmp    = 0;
    int  n_fail   = 0;
    int  n_writes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
        bus.push_valid = 1'b1;
        bus.push_addr  = a;
        bus.push_data  = d;
        if (expect_write) sb.push_back('{addr: a, data: d});
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.empty === 1'b1) break;
            @(negedge clk);
        end
        check(tag, 64'(bus.empty), 64'd1);
    endtask

    // Write monitor: each strobe seen mid-cycle is one pop at the next edge.
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wr_t e;
            n_writes++;
            check("ram_we_vs_model", 64'(bus.ram_we), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ram_waddr", 64'(bus.ram_waddr), 64'(e.addr));
                check("ram_wd", 64'(bus.ram_wd), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst            = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_addr  = '0;
        bus.push_data  = '0;
        bus.ram_busy   = 1'b0;
        bus.lk_addr    = '0;
        bus.flush      = 1'b0;

        // Reset state
        sample();
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_ram_we", 64'(bus.ram_we), 64'd0);
        check("rst_ram_waddr", 64'(bus.ram_waddr), 64'd0);
        check("rst_lk_hit", 64'(bus.lk_hit), 64'd0);
        check("rst_lk_data", 64'(bus.lk_data), 64'd0);
        check("rst_push_ready", 64'(bus.push_ready), 64'd1);
        bus.flush = 1'b1;
        #1;
        check("rst_push_ready_flush", 64'(bus.push_ready), 64'd0);
        bus.flush = 1'b0;
        step();
        rst = 1'b0;

        // Single push drains on the following cycle
        sample();
        check("t1_push_ready", 64'(bus.push_ready), 64'd1);
        step();
        push(32'h100, 32'hAAAA_0001, 1'b1);
        sample();
        check("t1_ram_we", 64'(bus.ram_we), 64'd1);
        check("t1_waddr", 64'(bus.ram_waddr), 64'h100);
        check("t1_wd", 64'(bus.ram_wd), 64'hAAAA_0001);
        step();
        sample();
        check("t1_empty", 64'(bus.empty), 64'd1);
        check("t1_idle_we", 64'(bus.ram_we), 64'd0);
        check("t1_idle_waddr", 64'(bus.ram_waddr), 64'd0);
        check("t1_idle_wd", 64'(bus.ram_wd), 64'd0);

        // Fill while RAM busy, overflow push ignored, drain in order
        step();
        bus.ram_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push(32'h1000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1);
        sample();
        check("t2_count_full", 64'(bus.count), 64'd4);
        check("t2_push_ready", 64'(bus.push_ready), 64'd0);
        check("t2_no_write_busy", 64'(bus.ram_we), 64'd0);
        step();
        push(32'h1010, 32'hDEAD_BEEF, 1'b0);
        sample();
        check("t2_count_after_ovf", 64'(bus.count), 64'd4);
        step();
        w0 = n_writes;
        bus.ram_busy = 1'b0;
        repeat (DEPTH) step();
        sample();
        check("t2_empty", 64'(bus.empty), 64'd1);
        check("t2_writes_4_cycles", 64'(n_writes - w0), 64'd4);

        // Lookup hit at word granularity, miss on next word
        step();
        bus.ram_busy = 1'b1;
        push(32'h200, 32'h1234_5678, 1'b1);
        bus.lk_addr = 32'h203;
        sample();
        check("t3_lk_hit", 64'(bus.lk_hit), 64'd1);
        check("t3_lk_data", 64'(bus.lk_data), 64'h1234_5678);
        bus.lk_addr = 32'h204;
        #1;
        check("t3_lk_miss", 64'(bus.lk_hit), 64'd0);
        check("t3_lk_miss_data", 64'(bus.lk_data), 64'd0);
        step();
        bus.ram_busy = 1'b0;
        wait_empty("t3_drain", 10);

        // Duplicate address: coalesced or kept in push order
        step();
        bus.ram_busy = 1'b1;
`ifdef WB_COALESCE_EN
        push(32'h300, 32'd1, 1'b0);
        push(32'h300, 32'd2, 1'b1);
        sample();
        check("t4_count", 64'(bus.count), 64'd1);
`else
        push(32'h300, 32'd1, 1'b1);
        push(32'h300, 32'd2, 1'b1);
        sample();
        check("t4_count", 64'(bus.count), 64'd2);
`endif
        bus.lk_addr = 32'h300;
        #1;
        check("t4_lk_hit", 64'(bus.lk_hit), 64'd1);
        check("t4_lk_newest", 64'(bus.lk_data), 64'd2);
        step();
        bus.ram_busy = 1'b0;
        wait_empty("t4_drain", 10);

        // Flush a full buffer
        step();
        bus.ram_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push(32'h4000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b1);
        w0 = n_writes;
        bus.flush      = 1'b1;
        bus.ram_busy   = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h5000;
        bus.push_data  = 32'h5555_5555;
        sample();
        check("t5_push_ready_flush", 64'(bus.push_ready), 64'd0);
        wait_empty("t5_flush_empty", 10);
        check("t5_flush_writes", 64'(n_writes - w0), 64'd4);
        check("t5_push_ready_hold", 64'(bus.push_ready), 64'd0);
        step();
        bus.push_valid = 1'b0;
        bus.flush      = 1'b0;
        #1;
        check("t5_push_ready_release", 64'(bus.push_ready), 64'd1);
        check("t5_still_empty", 64'(bus.count), 64'd0);

        // Reset in the middle of a drain
        bus.ram_busy = 1'b1;
        push(32'h600, 32'h0000_0600, 1'b1);
        push(32'h604, 32'h0000_0604, 1'b1);
        push(32'h608, 32'h0000_0608, 1'b1);
        bus.ram_busy = 1'b0;
        sample();
        check("t6_draining", 64'(bus.ram_we), 64'd1);
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_we", 64'(bus.ram_we), 64'd0);
        check("t6_rst_count", 64'(bus.count), 64'd0);
        check("t6_rst_empty", 64'(bus.empty), 64'd1);
        sb.delete();
        w0 = n_writes;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        sample();
        check("t6_no_writes_after", 64'(n_writes - w0), 64'd0);
        check("t6_count_after", 64'(bus.count), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
